// File: rtl/uart_sched_pkg.sv
// Shared types and sizing helpers for the UART TX scheduler.
// Imported by the arbiter and the scheduler top.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO,
        GAP
    } state_t;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Pointer value after reset: last requester, so requester 0 goes first.
    function automatic int rst_ptr(input int num_req);
        return num_req - 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte stream bundle for the UART TX scheduler.
// master = producers, slave = scheduler.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Rotating-priority picker: first requester after ptr, with wrap.
// Purely combinational; the caller decides when to latch.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    logic [ID_W-1:0] idx;

    // Scan farthest-first so the nearest candidate after ptr wins.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                gnt_id = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among several byte-stream requesters.
// Packet-locked round-robin grant, busy tracking, gap and hang timeout.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    uart_tx_scheduler_if.slave         req,
    output logic [DATA_WIDTH-1:0]      uart_data,
    output logic                       uart_tx_start,
    input  logic                       uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active,
    output logic                       timeout_err
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TW   = cnt_width(TIMEOUT_CYCLES);
    localparam int GW   = cnt_width(GAP_CYCLES);

    state_t                state_q;
    state_t                state_d;
    logic [ID_W-1:0]       ptr_q;
    logic                  last_q;
    logic [TW-1:0]         tmo_q;
    logic [GW-1:0]         gap_q;
    logic [ID_W-1:0]       arb_id;
    logic                  arb_any;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  tmo_hit;
    logic                  gap_done;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (req.req_valid),
        .ptr    (ptr_q),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    assign accept   = (state_q == LOAD) && req.req_valid[grant_id];
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES));
    assign gap_done = (GAP_CYCLES == 0) || (gap_q == GW'(GAP_CYCLES));

    // Byte of the granted requester.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_data = req.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the locked requester may see ready, and only while loading.
    always_comb begin
        req.req_ready = '0;
        if (state_q == LOAD) begin
            req.req_ready[grant_id] = req.req_valid[grant_id];
        end
    end

    // Next state plus the single-cycle start and timeout strobes.
    always_comb begin
        state_d       = state_q;
        uart_tx_start = 1'b0;
        timeout_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) state_d = LOAD;
            end
            LOAD: begin
                if (accept) state_d = START;
            end
            START: begin
                uart_tx_start = 1'b1;
                state_d       = WAIT_HI;
            end
            WAIT_HI: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_hit) begin
                    timeout_err = 1'b1;
                    state_d     = GAP;
                end
            end
            WAIT_LO: begin
                if (!uart_tx_busy) state_d = GAP;
            end
            GAP: begin
                if (gap_done) state_d = last_q ? IDLE : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grant, pointer, and accepted-byte registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= ID_W'(rst_ptr(NUM_REQ));
            grant_id     <= '0;
            grant_active <= 1'b0;
            uart_data    <= '0;
            last_q       <= 1'b0;
        end else begin
            if (state_q == IDLE && arb_any) begin
                grant_id     <= arb_id;
                grant_active <= 1'b1;
            end
            if (accept) begin
                uart_data <= sel_data;
                last_q    <= req.req_last[grant_id];
            end
            if (state_q == GAP && gap_done && last_q) begin
                ptr_q        <= grant_id;
                grant_active <= 1'b0;
            end
        end
    end

    // Busy-rise timeout counter and inter-byte gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            gap_q <= '0;
        end else begin
            if (state_q == START) begin
                tmo_q <= TW'(1);
            end else if (state_q == WAIT_HI && !tmo_hit) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (state_d == GAP && state_q != GAP) begin
                gap_q <= GW'(1);
            end else if (state_q == GAP && !gap_done) begin
                gap_q <= gap_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: arbitration table, directed corners,
// and randomized packets checked against a packet-level model.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 5;
    localparam int TMO = 16;

    typedef struct { logic [7:0] data; logic last; } beat_t;
    typedef struct { int id; logic [7:0] data; } exp_t;
    typedef struct { logic [3:0] mask; int exp_id; } arb_vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] uart_data;
    logic       uart_tx_start;
    logic       uart_tx_busy;
    logic [1:0] grant_id;
    logic       grant_active;
    logic       timeout_err;

    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (DW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (bus),
        .uart_data     (uart_data),
        .uart_tx_start (uart_tx_start),
        .uart_tx_busy  (uart_tx_busy),
        .grant_id      (grant_id),
        .grant_active  (grant_active),
        .timeout_err   (timeout_err)
    );

    int vectors = 0;
    int miscompares = 0;

    beat_t  q[N][$];
    exp_t   exp_q[$];
    int     hold[N];
    bit     mid[N];
    bit     rand_stall = 0;
    bit     rand_uart = 0;
    bit     uart_en = 1;
    int     u_wait, u_left;
    int     busy_dly = 2;
    int     busy_len = 10;
    int     cyc = 0;
    int     mptr;
    int     last_fall;
    logic [N-1:0] acc, prev_acc, prev_ready;
    bit     prev_busy, prev_ga;
    int     start_log[$], fall_log[$], rise_log[$], to_log[$], ga_fall_log[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void drive();
        logic v;
        for (int i = 0; i < N; i++) begin
            v = 1'b0;
            if (q[i].size() > 0) begin
                v = 1'b1;
                if (mid[i] && hold[i] > 0) begin
                    v = 1'b0;
                    hold[i]--;
                end else if (mid[i] && rand_stall && $urandom_range(0, 3) == 0) begin
                    v = 1'b0;
                end
            end
            bus.req_valid[i]       = v;
            bus.req_data[i*DW +: DW] = v ? q[i][0].data : 8'($urandom);
            bus.req_last[i]        = v ? q[i][0].last : 1'($urandom);
        end
    endfunction

    // Round-robin over whole packets: the next packet comes from the first
    // requester after the previous winner that still has one queued.
    function automatic void plan();
        int pos[N];
        int pick;
        int i;
        bit fin;
        for (int k = 0; k < N; k++) pos[k] = 0;
        repeat (64) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                i = (mptr + k) % N;
                if (pick < 0 && pos[i] < q[i].size()) pick = i;
            end
            if (pick < 0) break;
            fin = 0;
            while (!fin) begin
                exp_q.push_back('{pick, q[pick][pos[pick]].data});
                fin = q[pick][pos[pick]].last;
                pos[pick]++;
            end
            mptr = pick;
        end
    endfunction

    task automatic step();
        logic [N-1:0] rdy;
        bit st, to, bsy, ga, bad;
        exp_t e;
        @(negedge clk);
        rdy = bus.req_ready;
        st  = uart_tx_start;
        to  = timeout_err;
        bsy = uart_tx_busy;
        ga  = grant_active;
        acc = rdy & bus.req_valid;
        bad = ($countones(rdy) > 1) || ((rdy & ~bus.req_valid) != 0) ||
              (st && bsy) || (st != (prev_acc != 0)) || (to && uart_en);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL rules cyc %0d: ready=%b valid=%b start=%b busy=%b tmo=%b prev_acc=%b",
                     cyc, rdy, bus.req_valid, st, bsy, to, prev_acc);
        end
        if (st) begin
            start_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_start cyc %0d: data=%0h none expected", cyc, uart_data);
            end else begin
                e = exp_q.pop_front();
                check("start_data", uart_data, e.data);
                check("start_gid", grant_id, e.id);
            end
        end
        if (to) to_log.push_back(cyc);
        if (prev_busy && !bsy) begin
            fall_log.push_back(cyc);
            last_fall = cyc;
        end
        if (rdy != 0 && prev_ready == 0) begin
            rise_log.push_back(cyc);
            check("ready_after_gap", (cyc - last_fall >= GAP + 1), 1);
        end
        if (prev_ga && !ga) ga_fall_log.push_back(cyc);
        prev_busy  = bsy;
        prev_ga    = ga;
        prev_ready = rdy;
        prev_acc   = acc;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                mid[i] = !q[i][0].last;
                q[i].delete(0);
            end
        end
        if (u_left > 0) begin
            u_left--;
            if (u_left == 0) uart_tx_busy = 1'b0;
        end else if (u_wait > 0) begin
            u_wait--;
            if (u_wait == 0) begin
                uart_tx_busy = 1'b1;
                u_left = busy_len;
            end
        end
        if (st && uart_en) begin
            if (rand_uart) begin
                u_wait   = $urandom_range(1, 6);
                busy_len = $urandom_range(1, 12);
            end else begin
                u_wait = busy_dly;
            end
        end
        drive();
    endtask

    function automatic bit done();
        bit empty = 1;
        for (int i = 0; i < N; i++) if (q[i].size() != 0) empty = 0;
        return empty && exp_q.size() == 0 && !prev_ga &&
               u_left == 0 && u_wait == 0 && !uart_tx_busy;
    endfunction

    task automatic run_until_done(input int max, input string name);
        int n = 0;
        forever begin
            step();
            n++;
            if (done() || n >= max) break;
        end
        check(name, done(), 1);
    endtask

    task automatic clear_logs();
        start_log.delete();
        fall_log.delete();
        rise_log.delete();
        to_log.delete();
        ga_fall_log.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, bus.req_ready, 0);
        check({tag, "_data"}, uart_data, 0);
        check({tag, "_start"}, uart_tx_start, 0);
        check({tag, "_gid"}, grant_id, 0);
        check({tag, "_gactive"}, grant_active, 0);
        check({tag, "_tmo"}, timeout_err, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            mid[i]  = 0;
            hold[i] = 0;
        end
        exp_q.delete();
        clear_logs();
        u_wait = 0;
        u_left = 0;
        uart_tx_busy = 1'b0;
        prev_acc   = '0;
        prev_ready = '0;
        prev_busy  = 0;
        prev_ga    = 0;
        last_fall  = -1000;
        mptr       = N - 1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        arb_vec_t tab[8];
        int n;
        bit got;
        logic [7:0] d;

        tab = '{'{4'b1111, 0}, '{4'b1111, 1}, '{4'b0101, 2}, '{4'b0011, 0},
                '{4'b1000, 3}, '{4'b1000, 3}, '{4'b0110, 1}, '{4'b0001, 0}};

        uart_tx_busy = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outs("reset");
        do_reset();

        // Arbitration table: one single-byte packet per masked requester.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++) begin
                d = 8'(16 * v + i + 1);
                if (tab[v].mask[i]) q[i].push_back('{d, 1'b1});
            end
            d = 8'(16 * v + tab[v].exp_id + 1);
            exp_q.push_back('{tab[v].exp_id, d});
            drive();
            n = 0;
            got = 0;
            while (!got && n < 40) begin
                step();
                n++;
                if (acc != 0) got = 1;
            end
            check($sformatf("arb%0d_accept", v), acc, 32'(1) << tab[v].exp_id);
            for (int i = 0; i < N; i++) q[i].delete();
            drive();
            run_until_done(200, $sformatf("arb%0d_drain", v));
        end

        // Three-byte packet from requester 0, exact gap and release timing.
        do_reset();
        q[0].push_back('{8'h55, 1'b0});
        q[0].push_back('{8'hA3, 1'b0});
        q[0].push_back('{8'h0F, 1'b1});
        plan();
        drive();
        run_until_done(300, "t1_done");
        check("t1_starts", start_log.size(), 3);
        check("t1_falls", fall_log.size(), 3);
        check("t1_rises", rise_log.size(), 3);
        if (fall_log.size() == 3 && rise_log.size() == 3 && ga_fall_log.size() == 1) begin
            check("t1_gap_b2", rise_log[1] - fall_log[0], GAP + 1);
            check("t1_gap_b3", rise_log[2] - fall_log[1], GAP + 1);
            check("t1_release", ga_fall_log[0] - fall_log[2], GAP + 1);
        end

        // Requester 1 stalls mid-packet while requester 2 waits.
        clear_logs();
        q[1].push_back('{8'h11, 1'b0});
        q[1].push_back('{8'h22, 1'b0});
        q[1].push_back('{8'h33, 1'b1});
        q[2].push_back('{8'h44, 1'b1});
        hold[1] = 40;
        plan();
        drive();
        run_until_done(600, "t3_done");
        check("t3_starts", start_log.size(), 4);
        check("t3_releases", ga_fall_log.size(), 2);
        if (start_log.size() == 4 && ga_fall_log.size() == 2) begin
            check("t3_stall_len", start_log[1] - start_log[0], 41);
            check("t3_held", ga_fall_log[0] > start_log[2], 1);
        end

        // UART never goes busy: timeout pulse, then the FSM moves on.
        clear_logs();
        uart_en = 0;
        q[3].push_back('{8'h5A, 1'b1});
        plan();
        drive();
        run_until_done(200, "t5_done");
        check("t5_pulses", to_log.size(), 1);
        check("t5_starts", start_log.size(), 1);
        if (to_log.size() == 1 && start_log.size() == 1 && ga_fall_log.size() == 1) begin
            check("t5_latency", to_log[0] - start_log[0], TMO);
            check("t5_release", ga_fall_log[0] - to_log[0], GAP + 1);
        end
        uart_en = 1;

        // Reset while the UART is busy, then all four contend from reset.
        clear_logs();
        q[1].push_back('{8'h66, 1'b0});
        q[1].push_back('{8'h77, 1'b1});
        plan();
        drive();
        n = 0;
        while (!prev_busy && n < 100) begin
            step();
            n++;
        end
        check("t6_reach_busy", prev_busy, 1);
        rst_n = 1'b0;
        #1 check_reset_outs("t6_midreset");
        do_reset();
        q[0].push_back('{8'hC0, 1'b1});
        q[0].push_back('{8'hC4, 1'b1});
        q[1].push_back('{8'hC1, 1'b1});
        q[2].push_back('{8'hC2, 1'b1});
        q[3].push_back('{8'hC3, 1'b1});
        plan();
        drive();
        run_until_done(800, "t2_done");
        check("t2_starts", start_log.size(), 5);

        // Randomized packets, stalls and UART timing.
        rand_stall = 1;
        rand_uart  = 1;
        for (int r = 0; r < 3; r++) begin
            int npk, len;
            clear_logs();
            for (int i = 0; i < N; i++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        q[i].push_back('{8'($urandom), 1'(b == len - 1)});
                    end
                end
            end
            plan();
            drive();
            run_until_done(6000, $sformatf("rand%0d_done", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
